// File: rtl/activation_execution_if.sv
// Bundle between the activation unit and its controller/buffer side.
// master = activation unit, slave = command source plus buffer controller.
interface activation_execution_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int TILE_ELEMS   = 32,
   parameter int LEN_WIDTH    = 10,
   parameter int BUF_ID_WIDTH = 5
);
   logic                                  start;
   logic [1:0]                            mode;
   logic [2:0]                            shift;
   logic signed [DATA_WIDTH-1:0]          clamp_max;
   logic [LEN_WIDTH-1:0]                  length;
   logic [BUF_ID_WIDTH-1:0]               x_buffer_id;
   logic [BUF_ID_WIDTH-1:0]               dest_buffer_id;
   logic                                  busy;
   logic                                  done;
   logic                                  vec_read_enable;
   logic [BUF_ID_WIDTH-1:0]               vec_read_buffer_id;
   logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile;
   logic                                  vec_read_valid;
   logic                                  vec_write_enable;
   logic [BUF_ID_WIDTH-1:0]               vec_write_buffer_id;
   logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile;
   logic                                  vec_write_ready;

   modport master (
      input  start, mode, shift, clamp_max, length, x_buffer_id, dest_buffer_id,
             vec_read_tile, vec_read_valid, vec_write_ready,
      output busy, done, vec_read_enable, vec_read_buffer_id,
             vec_write_enable, vec_write_buffer_id, vec_write_tile
   );

   modport slave (
      output start, mode, shift, clamp_max, length, x_buffer_id, dest_buffer_id,
             vec_read_tile, vec_read_valid, vec_write_ready,
      input  busy, done, vec_read_enable, vec_read_buffer_id,
             vec_write_enable, vec_write_buffer_id, vec_write_tile
   );
endinterface

// File: rtl/activation_execution.sv
// Tile-streaming element-wise activation (identity / ReLU / leaky / clamped ReLU)
// with variable read latency and write backpressure.
module activation_lane #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]        x,
   input  logic                         in_range,
   input  logic [1:0]                   mode,
   input  logic [2:0]                   shift,
   input  logic signed [DATA_WIDTH-1:0] clamp_max,
   output logic [DATA_WIDTH-1:0]        y
);
   logic signed [DATA_WIDTH-1:0] xs, relu, cap;

   assign xs   = x;
   assign relu = xs[DATA_WIDTH-1] ? '0 : xs;
   assign cap  = clamp_max[DATA_WIDTH-1] ? '0 : clamp_max;

   always_comb begin
      y = '0;
      if (in_range) begin
         case (mode)
            2'd0:    y = xs;
            2'd1:    y = relu;
            2'd2:    y = xs[DATA_WIDTH-1] ? (xs >>> shift) : xs;
            default: y = (relu > cap) ? cap : relu;
         endcase
      end
   end
endmodule

module activation_execution #(
   parameter int DATA_WIDTH   = 8,
   parameter int TILE_ELEMS   = 32,
   parameter int LEN_WIDTH    = 10,
   parameter int BUF_ID_WIDTH = 5
) (
   input logic                 clk,
   input logic                 rst,
   activation_execution_if.master bus
);
   localparam int CW = LEN_WIDTH + 1;
   localparam logic [CW-1:0] TILE_L = CW'(TILE_ELEMS);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, WRITE, FINISH} state_t;
   state_t state, state_nx;

   logic [1:0]                            mode_q;
   logic [2:0]                            shift_q;
   logic signed [DATA_WIDTH-1:0]          clamp_q;
   logic [CW-1:0]                         len_q, total_q, count_q, offset_q;
   logic [CW-1:0]                         len_in;
   logic                                  last_tile;
   logic [TILE_ELEMS-1:0]                 in_rng;
   logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] act_tile;

   assign len_in    = CW'(bus.length);
   assign last_tile = (count_q + CW'(1)) >= total_q;

   // One lane per element; lanes past the vector end are forced to zero.
   for (genvar i = 0; i < TILE_ELEMS; i++) begin : g_lane
      assign in_rng[i] = (offset_q + CW'(i)) < len_q;
      activation_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .x         (bus.vec_read_tile[i]),
         .in_range  (in_rng[i]),
         .mode      (mode_q),
         .shift     (shift_q),
         .clamp_max (clamp_q),
         .y         (act_tile[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = (bus.length == '0) ? FINISH : REQ;
         REQ:     state_nx = WAIT_RD;
         WAIT_RD: if (bus.vec_read_valid) state_nx = WRITE;
         WRITE:   if (bus.vec_write_ready) state_nx = last_tile ? FINISH : REQ;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy             = (state != IDLE);
      bus.done             = (state == FINISH);
      bus.vec_read_enable  = (state == REQ);
      bus.vec_write_enable = (state == WRITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q                  <= '0;
         shift_q                 <= '0;
         clamp_q                 <= '0;
         len_q                   <= '0;
         total_q                 <= '0;
         count_q                 <= '0;
         offset_q                <= '0;
         bus.vec_read_buffer_id  <= '0;
         bus.vec_write_buffer_id <= '0;
         bus.vec_write_tile      <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               mode_q                  <= bus.mode;
               shift_q                 <= bus.shift;
               clamp_q                 <= bus.clamp_max;
               len_q                   <= len_in;
               total_q                 <= (len_in + TILE_L - CW'(1)) / TILE_L;
               count_q                 <= '0;
               offset_q                <= '0;
               bus.vec_read_buffer_id  <= bus.x_buffer_id;
               bus.vec_write_buffer_id <= bus.dest_buffer_id;
            end
            WAIT_RD: if (bus.vec_read_valid) bus.vec_write_tile <= act_tile;
            WRITE: if (bus.vec_write_ready) begin
               count_q  <= count_q + CW'(1);
               offset_q <= offset_q + TILE_L;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_activation_execution.sv
// Randomised scoreboard bench: a buffer responder supplies tiles and queues the
// reference result; the write monitor pops and compares on every accepted write.
module tb_activation_execution;
   localparam int DW = 8, TE = 32, LW = 10, BW = 5;
   typedef logic [TE-1:0][DW-1:0] tile_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   activation_execution_if #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .LEN_WIDTH(LW), .BUF_ID_WIDTH(BW)) ifc ();
   activation_execution #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .LEN_WIDTH(LW), .BUF_ID_WIDTH(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int checks = 0, errors = 0, e_checks = 0, e_errors = 0;
   int cyc = 0, reads = 0, writes = 0, dones = 0, last_acc = -10, done_cyc = -10;
   tile_t exp_q[$];
   tile_t first_wtile, last_wtile, prev_tile, ptile;
   int op_len = 0, op_mode = 0, op_sh = 0, op_cmax = 0, op_lat = 1, op_rd_base = 0, op_wr_base = 0;
   logic [BW-1:0] op_xid = '0, op_did = '0;
   bit bp_en = 0, rnd_ready = 0, spur_en = 0;
   int stall = 0, pcnt = 0;
   bit we_prev = 0, acc_prev = 0, pend = 0;
   logic [DW-1:0] pre_vals [4];
   int pre_n = 0;

   // Activation straight from its definition, in integer arithmetic.
   function automatic int ref_act(int x, int mode, int sh, int cmax, bit inr);
      int c, p, q;
      if (!inr) return 0;
      case (mode)
         0: return x;
         1: return (x < 0) ? 0 : x;
         2: begin
            if (x >= 0) return x;
            p = 1 << sh;
            q = x / p;
            if (q * p != x) q = q - 1;
            return q;
         end
         default: begin
            c = (cmax < 0) ? 0 : cmax;
            if (x < 0) return 0;
            return (x > c) ? c : x;
         end
      endcase
   endfunction

   task automatic chk_m(bit ok, string nm, logic [TE*DW-1:0] act, logic [TE*DW-1:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_e(bit ok, string nm, logic [TE*DW-1:0] act, logic [TE*DW-1:0] req);
      e_checks++;
      if (!ok) begin
         e_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Environment: write-ready driver, write monitor, buffer responder.
   always @(negedge clk) begin
      tile_t t, e;
      int idx;
      bit acc;
      cyc++;
      if (bp_en) begin
         if (ifc.vec_write_enable && !we_prev) stall = 3;
         ifc.vec_write_ready = (stall == 0);
         if (stall > 0) stall--;
      end else if (rnd_ready) ifc.vec_write_ready = ($urandom_range(0, 3) != 0);
      else ifc.vec_write_ready = 1'b1;

      if (we_prev && !acc_prev)
         chk_e(ifc.vec_write_enable && ifc.vec_write_tile == prev_tile, "wr_hold",
               ifc.vec_write_tile, prev_tile);
      if (ifc.vec_write_enable)
         chk_e(!ifc.vec_read_enable, "rd_during_wr", ifc.vec_read_enable, 0);

      acc = ifc.vec_write_enable && ifc.vec_write_ready;
      if (acc) begin
         if (writes == op_wr_base) first_wtile = ifc.vec_write_tile;
         last_wtile = ifc.vec_write_tile;
         writes++;
         last_acc = cyc;
         chk_e(ifc.vec_write_buffer_id == op_did, "wr_id", ifc.vec_write_buffer_id, op_did);
         if (exp_q.size() == 0) chk_e(0, "unexpected_write", ifc.vec_write_tile, 0);
         else begin
            e = exp_q.pop_front();
            chk_e(ifc.vec_write_tile == e, "wr_tile", ifc.vec_write_tile, e);
         end
      end
      we_prev   = ifc.vec_write_enable;
      acc_prev  = acc;
      prev_tile = ifc.vec_write_tile;
      if (ifc.done) begin
         dones++;
         done_cyc = cyc;
      end

      ifc.vec_read_valid = 1'b0;
      if (pend) begin
         if (pcnt <= 1) begin
            ifc.vec_read_valid = 1'b1;
            ifc.vec_read_tile  = ptile;
            pend = 0;
         end else pcnt--;
      end
      if (ifc.vec_read_enable) begin
         idx = reads - op_rd_base;
         reads++;
         chk_e(ifc.vec_read_buffer_id == op_xid, "rd_id", ifc.vec_read_buffer_id, op_xid);
         for (int i = 0; i < TE; i++) begin
            t[i] = (idx == 0 && i < pre_n) ? pre_vals[i] : DW'($urandom);
            e[i] = DW'(ref_act(int'($signed(t[i])), op_mode, op_sh, op_cmax, (idx * TE + i) < op_len));
         end
         exp_q.push_back(e);
         ptile = t;
         pend  = 1;
         pcnt  = op_lat;
         if (spur_en && !ifc.vec_read_valid) begin
            ifc.vec_read_valid = 1'b1;
            for (int i = 0; i < TE; i++) ifc.vec_read_tile[i] = DW'($urandom);
         end
      end
      if (rst) exp_q.delete();
   end

   task automatic run_op(int len, int mode, int sh, int cmax, int lat, bit bp, bit rr, bit spur, bit glitch);
      int rb, wb, db, tiles, n;
      @(negedge clk); #1;
      op_len = len; op_mode = mode; op_sh = sh; op_cmax = cmax; op_lat = lat;
      bp_en = bp; rnd_ready = rr; spur_en = spur;
      op_xid = BW'($urandom); op_did = BW'($urandom);
      op_rd_base = reads; op_wr_base = writes;
      rb = reads; wb = writes; db = dones;
      ifc.start = 1'b1; ifc.mode = 2'(mode); ifc.shift = 3'(sh); ifc.clamp_max = DW'(cmax);
      ifc.length = LW'(len); ifc.x_buffer_id = op_xid; ifc.dest_buffer_id = op_did;
      @(negedge clk); #1;
      ifc.start = 1'b0;
      chk_m(ifc.busy == 1'b1, "busy_t1", ifc.busy, 1);
      chk_m(ifc.vec_read_enable == (len != 0), "rd_en_t1", ifc.vec_read_enable, len != 0);
      chk_m(ifc.done == (len == 0), "done_t1", ifc.done, len == 0);
      if (glitch) begin
         ifc.start = 1'b1; ifc.mode = ~ifc.mode; ifc.length = LW'(len + 100);
         ifc.x_buffer_id = ~op_xid; ifc.dest_buffer_id = ~op_did; ifc.clamp_max = DW'(-1);
         @(negedge clk); #1;
         ifc.start = 1'b0;
      end
      n = 0;
      while (dones == db && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      chk_m(dones != db, "done_timeout", n, 0);
      tiles = (len + TE - 1) / TE;
      chk_m(reads - rb == tiles, "read_count", reads - rb, tiles);
      chk_m(writes - wb == tiles, "write_count", writes - wb, tiles);
      chk_m(exp_q.size() == 0, "tiles_outstanding", exp_q.size(), 0);
      if (tiles > 0) chk_m(done_cyc == last_acc + 1, "done_latency", done_cyc - last_acc, 1);
      @(negedge clk); #1;
      chk_m(ifc.busy == 1'b0, "busy_after", ifc.busy, 0);
      chk_m(ifc.done == 1'b0, "done_one_cycle", ifc.done, 0);
      chk_m(dones - db == 1, "done_count", dones - db, 1);
   endtask

   task automatic chk_outputs_zero(string nm);
      chk_m({ifc.busy, ifc.done, ifc.vec_read_enable, ifc.vec_write_enable} == '0,
            {nm, "_ctrl"}, {ifc.busy, ifc.done, ifc.vec_read_enable, ifc.vec_write_enable}, 0);
      chk_m({ifc.vec_read_buffer_id, ifc.vec_write_buffer_id} == '0, {nm, "_ids"},
            {ifc.vec_read_buffer_id, ifc.vec_write_buffer_id}, 0);
      chk_m(ifc.vec_write_tile == '0, {nm, "_tile"}, ifc.vec_write_tile, 0);
   endtask

   initial begin
      int rb, wb, len, pick;
      int blen [7];
      blen = '{0, 1, 31, 32, 33, 64, 1023};
      rst = 1'b1;
      ifc.start = 1'b0; ifc.mode = '0; ifc.shift = '0; ifc.clamp_max = '0;
      ifc.length = '0; ifc.x_buffer_id = '0; ifc.dest_buffer_id = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;

      // ReLU over a 40-element vector: two tiles, second mostly tail
      pre_n = 2; pre_vals[0] = 8'hFB; pre_vals[1] = 8'h07;
      run_op(40, 1, 0, 0, 1, 0, 0, 0, 0);
      chk_m(first_wtile[0] == 8'h00 && first_wtile[1] == 8'h07, "relu_t0",
            {first_wtile[1], first_wtile[0]}, 16'h0700);
      chk_m(last_wtile[TE-1:8] == '0, "relu_tail", last_wtile[TE-1:8], 0);

      pre_n = 4; pre_vals[0] = 8'hF8; pre_vals[1] = 8'hFF; pre_vals[2] = 8'h80; pre_vals[3] = 8'h05;
      run_op(4, 2, 2, 0, 1, 0, 0, 0, 0);
      chk_m(first_wtile[3:0] == 32'h05E0FFFE, "leaky", first_wtile[3:0], 32'h05E0FFFE);

      pre_n = 3; pre_vals[0] = 8'hFD; pre_vals[1] = 8'h04; pre_vals[2] = 8'h64;
      run_op(3, 3, 0, 6, 1, 0, 0, 0, 0);
      chk_m(first_wtile[2:0] == 24'h060400, "clamp6", first_wtile[2:0], 24'h060400);
      run_op(3, 3, 0, -4, 1, 0, 0, 0, 0);
      chk_m(first_wtile == '0, "clamp_neg", first_wtile, 0);
      pre_n = 0;

      run_op(70, 1, 0, 0, 4, 1, 0, 0, 0);
      run_op(0, 1, 0, 0, 1, 0, 0, 0, 0);
      run_op(50, 2, 1, 0, 2, 0, 0, 1, 1);

      // Reset while waiting for read data
      @(negedge clk); #1;
      op_len = 64; op_mode = 1; op_lat = 3; op_xid = 5'h0A; op_did = 5'h15;
      bp_en = 0; rnd_ready = 0; spur_en = 0; op_rd_base = reads; op_wr_base = writes;
      ifc.start = 1'b1; ifc.mode = 2'd1; ifc.length = LW'(64);
      ifc.x_buffer_id = op_xid; ifc.dest_buffer_id = op_did;
      @(negedge clk); #1;
      ifc.start = 1'b0;
      chk_m(ifc.vec_read_enable == 1'b1, "rst_test_rd", ifc.vec_read_enable, 1);
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      chk_outputs_zero("mid_reset");
      rst = 1'b0;
      rb = reads; wb = writes;
      repeat (10) @(negedge clk);
      #1;
      chk_m(reads == rb && writes == wb, "no_io_after_reset", {reads - rb, writes - wb}, 0);
      chk_m(ifc.busy == 1'b0, "idle_after_reset", ifc.busy, 0);

      for (int k = 0; k < 25; k++) begin
         pick = $urandom_range(0, 9);
         len = (pick < 3) ? blen[$urandom_range(0, 6)] : $urandom_range(1, 200);
         run_op(len, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255) - 128,
                $urandom_range(1, 5), 0, 1, $urandom_range(0, 1), $urandom_range(0, 1) && len != 0);
      end

      errors += e_errors;
      checks += e_checks;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
